// File: rtl/face_color_store.sv
// Stores six classified cube faces (54 stickers) and checks colour counts.
// Colour codes: W=0 Y=1 O=2 R=3 G=4 B=5, empty entry = 7.
module face_color_store #(
    parameter logic [9:0] TH_HI = 10'd600,
    parameter logic [9:0] TH_LO = 10'd300
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Clear,
    input  logic         facedone,
    input  logic [269:0] ColorBus,
    input  logic [5:0]   rd_addr,
    output logic [2:0]   rd_code,
    output logic [2:0]   face_idx,
    output logic         busy,
    output logic         face_stored,
    output logic         algstart,
    output logic         cube_valid,
    output logic         cube_error
);

    localparam logic [2:0] C_WHITE  = 3'd0;
    localparam logic [2:0] C_YELLOW = 3'd1;
    localparam logic [2:0] C_ORANGE = 3'd2;
    localparam logic [2:0] C_RED    = 3'd3;
    localparam logic [2:0] C_GREEN  = 3'd4;
    localparam logic [2:0] C_BLUE   = 3'd5;
    localparam logic [2:0] C_EMPTY  = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLASSIFY,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t         state_q, state_d;
    logic [2:0]     face_idx_q, face_idx_d;
    logic [3:0]     s_q, s_d;
    logic [269:0]   bus_q, bus_d;
    logic [2:0]     mem_q [54];
    logic [2:0]     mem_d [54];
    logic [5:0]     cnt_q [6];
    logic [5:0]     cnt_d [6];
    logic [2:0]     rd_code_q, rd_code_d;
    logic           face_stored_q, face_stored_d;
    logic           algstart_q, algstart_d;

    logic [8:0]     off;
    logic [29:0]    stk;
    logic [9:0]     r, g, b;
    logic [2:0]     code;
    logic [5:0]     wr_addr;
    logic           all_nine;

    // Classify the latched sticker selected by the sticker counter.
    always_comb begin
        off  = 9'(s_q) * 9'd30;
        stk  = bus_q[off +: 30];
        r    = stk[29:20];
        g    = stk[19:10];
        b    = stk[9:0];
        code = C_BLUE;
        if (r > TH_HI && g > TH_HI && b > TH_HI)
            code = C_WHITE;
        else if (r > TH_HI && g > TH_HI)
            code = C_YELLOW;
        else if (r > TH_HI && g >= TH_LO)
            code = C_ORANGE;
        else if (r > TH_HI)
            code = C_RED;
        else if (g >= r && g >= b)
            code = C_GREEN;
        wr_addr = 6'(face_idx_q) * 6'd9 + 6'(s_q);
    end

    // A legal cube has exactly nine stickers of every colour.
    always_comb begin
        all_nine = 1'b1;
        for (int i = 0; i < 6; i++)
            if (cnt_q[i] != 6'd9)
                all_nine = 1'b0;
    end

    // Next-state logic: latch a face, classify it sticker by sticker, verify.
    always_comb begin
        state_d       = state_q;
        face_idx_d    = face_idx_q;
        s_d           = s_q;
        bus_d         = bus_q;
        mem_d         = mem_q;
        cnt_d         = cnt_q;
        face_stored_d = 1'b0;
        algstart_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (facedone && face_idx_q < 3'd6) begin
                    bus_d   = ColorBus;
                    s_d     = 4'd0;
                    state_d = S_CLASSIFY;
                end
            end
            S_CLASSIFY: begin
                mem_d[wr_addr] = code;
                cnt_d[code]    = cnt_q[code] + 6'd1;
                if (s_q == 4'd8) begin
                    s_d           = 4'd0;
                    face_idx_d    = face_idx_q + 3'd1;
                    face_stored_d = 1'b1;
                    state_d = (face_idx_q == 3'd5) ? S_CHECK : S_IDLE;
                end else begin
                    s_d = s_q + 4'd1;
                end
            end
            S_CHECK: begin
                if (all_nine) begin
                    state_d    = S_DONE;
                    algstart_d = 1'b1;
                end else begin
                    state_d = S_ERROR;
                end
            end
            S_DONE:  state_d = S_DONE;
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_IDLE;
        endcase
    end

    // Registered read port; addresses past the last sticker read as empty.
    always_comb begin
        rd_code_d = (rd_addr > 6'd53) ? C_EMPTY : mem_q[rd_addr];
    end

    // State registers; Clear behaves exactly like Reset.
    always_ff @(posedge Clk) begin
        if (Reset || Clear) begin
            state_q       <= S_IDLE;
            face_idx_q    <= 3'd0;
            s_q           <= 4'd0;
            bus_q         <= '0;
            rd_code_q     <= C_EMPTY;
            face_stored_q <= 1'b0;
            algstart_q    <= 1'b0;
            for (int i = 0; i < 54; i++)
                mem_q[i] <= C_EMPTY;
            for (int i = 0; i < 6; i++)
                cnt_q[i] <= 6'd0;
        end else begin
            state_q       <= state_d;
            face_idx_q    <= face_idx_d;
            s_q           <= s_d;
            bus_q         <= bus_d;
            rd_code_q     <= rd_code_d;
            face_stored_q <= face_stored_d;
            algstart_q    <= algstart_d;
            mem_q         <= mem_d;
            cnt_q         <= cnt_d;
        end
    end

    assign rd_code     = rd_code_q;
    assign face_idx    = face_idx_q;
    assign face_stored = face_stored_q;
    assign algstart    = algstart_q;
    assign busy        = (state_q == S_CLASSIFY) || (state_q == S_CHECK);
    assign cube_valid  = (state_q == S_DONE);
    assign cube_error  = (state_q == S_ERROR);

endmodule

// File: doc/face_color_store.md
FACE_COLOR_STORE -- requirements
Module: face_color_store

Interface
REQ-001 SHALL have parameter TH_HI, default 10'd600: per-channel "high" threshold, strict greater-than.
REQ-002 SHALL have parameter TH_LO, default 10'd300: per-channel "low" threshold, strict less-than.
REQ-003 SHALL have port Clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port Clear, input, 1 bit: synchronous pulse; restarts the cube scan.
REQ-006 SHALL have port facedone, input, 1 bit: one-cycle pulse from the colour-detection stage meaning a face's colours are valid.
REQ-007 SHALL have port ColorBus, input, 270 bits: sticker k (1..9) at [30k-1:30k-30]; each sticker is R[29:20], G[19:10], B[9:0], unsigned.
REQ-008 SHALL have port rd_addr, input, 6 bits: sticker read address, face*9+sticker (0..53).
REQ-009 SHALL have port rd_code, output, 3 bits: registered colour code at rd_addr.
REQ-010 SHALL have port face_idx, output, 3 bits: number of faces stored so far (0..6).
REQ-011 SHALL have port busy, output, 1 bit: high while the state is not IDLE, DONE or ERROR.
REQ-012 SHALL have port face_stored, output, 1 bit: one-cycle pulse when a face has been written.
REQ-013 SHALL have port algstart, output, 1 bit: one-cycle pulse on entry to DONE.
REQ-014 SHALL have port cube_valid, output, 1 bit: level, high in DONE.
REQ-015 SHALL have port cube_error, output, 1 bit: level, high in ERROR.

Function
REQ-016 SHALL use colour codes WHITE=0, YELLOW=1, ORANGE=2, RED=3, GREEN=4, BLUE=5, EMPTY=7.
REQ-017 SHALL classify each sticker by the first matching rule, in this order:
- R>TH_HI and G>TH_HI and B>TH_HI -> WHITE
- R>TH_HI and G>TH_HI -> YELLOW
- R>TH_HI and G>=TH_LO -> ORANGE
- R>TH_HI -> RED
- G>=R and G>=B -> GREEN
- else -> BLUE
REQ-018 SHALL implement states IDLE, CLASSIFY, CHECK, DONE and ERROR.
REQ-019 SHALL, in IDLE with facedone=1 and face_idx<6, latch all 270 bits of ColorBus, set sticker counter s=0 and enter CLASSIFY on the next edge.
REQ-020 SHALL, in CLASSIFY, classify one latched sticker per cycle, write code to entry face_idx*9+s, increment the counter of that colour and increment s.
REQ-021 SHALL, when s=8 is written, increment face_idx, pulse face_stored, and return to IDLE (face_idx<6) or enter CHECK (face_idx becomes 6).
REQ-022 SHALL give fixed latency: facedone sampled at edge t, face_stored high in the cycle after edge t+9.
REQ-023 SHALL ignore facedone in CLASSIFY, CHECK, DONE and ERROR; ColorBus changes after the latch SHALL have no effect.
REQ-024 SHALL, in CHECK (one cycle), enter DONE if all six colour counters equal 9, else enter ERROR.
REQ-025 SHALL stay in DONE or ERROR until Clear or Reset.
REQ-026 SHALL use six 6-bit colour counters (max 54), no saturation needed.
REQ-027 SHALL update rd_code one cycle after rd_addr is sampled; rd_addr>53 returns EMPTY.
REQ-028 SHALL, on a Clear pulse in any state, perform the same actions as Reset on the next edge; Clear in the same cycle as facedone SHALL win.
REQ-029 SHALL, on a reset mid-CLASSIFY, discard the partial face (face_idx unchanged at 0 after reset).

Reset
REQ-030 SHALL, on Reset=1 at an edge, set: state IDLE; face_idx=0; s=0; all 54 entries EMPTY; counters 0; rd_code=7; busy=0; face_stored=0; algstart=0; cube_valid=0; cube_error=0.

Verification
REQ-031 SHALL cover single face: all stickers R=G=B=10'd900, facedone pulse -> entries 0..8 = 0, face_stored after 10 cycles, face_idx=1.
REQ-032 SHALL cover classification boundaries: R=601,G=300,B=0 -> ORANGE; R=601,G=299 -> RED; R=600,G=600,B=600 -> GREEN; R=600,G=500,B=600 -> BLUE.
REQ-033 SHALL cover a legal cube: six faces, each with nine stickers of one distinct colour -> CHECK, algstart one pulse, cube_valid=1, face_idx=6.
REQ-034 SHALL cover an illegal cube: six all-white faces -> cube_error=1, algstart never asserted, further facedone ignored.
REQ-035 SHALL cover facedone during CLASSIFY: second pulse 3 cycles after the first -> ignored, face_idx=1, only one face_stored pulse.
REQ-036 SHALL cover Clear mid-CLASSIFY and in DONE -> all outputs at reset values, rd_code=7 for addresses 0..53.
